// File: rtl/moxie_fetch_queue.sv
// moxie_fetch_queue: instruction-fetch front end for the moxie decoder.
// Fetches 32-bit big-endian words into a byte queue and presents a 6-byte window
// (16-bit opcode + 32-bit immediate) at the queue head. The decoder consumes
// 2, 4 or 6 bytes at a time. A redirect flushes the queue and restarts fetch.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   redir_i, redir_pc_i     restart fetch at redir_pc_i (even address)
//   mem_req_o, mem_addr_o   word read request / word-aligned address
//   mem_ack_i, mem_rdata_i  read completion and data ([31:24] = lowest byte)
//   valid_o                 full 6-byte window available
//   insn_o, data_o, pc_o    queue bytes 0..1, bytes 2..5, address of byte 0
//   consume_i, length_i     decoder accepts current instruction of length_i bytes
//   err_o                   sticky illegal-consume / odd-redirect flag
module moxie_fetch_queue #(
    parameter int unsigned QDEPTH   = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redir_i,
    input  logic [31:0] redir_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        valid_o,
    output logic [15:0] insn_o,
    output logic [31:0] data_o,
    output logic [31:0] pc_o,
    input  logic        consume_i,
    input  logic [2:0]  length_i,
    output logic        err_o
);

    localparam int unsigned CW  = $clog2(QDEPTH + 1);
    localparam int unsigned IW  = $clog2(QDEPTH);
    localparam int unsigned WIN = 6;
    localparam logic [CW-1:0] REQ_LIMIT = CW'(QDEPTH - 4);
    localparam logic [CW-1:0] WIN_BYTES = CW'(WIN);
    localparam logic [31:0]   RESET_FA  = {RESET_PC[31:2], 2'b00};

    // State
    logic [7:0]    q_q [QDEPTH];
    logic [7:0]    q_d [QDEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fa_q, fa_d;
    logic          drop_first_q, drop_first_d;
    logic          discard_q, discard_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_q, err_d;

    // Combinational helpers
    logic          valid_c;
    logic          len_ok_c;
    logic          ack_take_c;
    logic [2:0]    shift_c;
    logic [CW-1:0] base_c;
    logic [7:0]    app_c [4];
    logic [2:0]    app_n_c;

    assign valid_c = (count_q >= WIN_BYTES);

    // Bytes to append from the returned word; a half-word-aligned start skips the upper half.
    always_comb begin
        len_ok_c = (length_i == 3'd2) || (length_i == 3'd4) || (length_i == 3'd6);
        if (drop_first_q) begin
            app_c[0] = mem_rdata_i[15:8];
            app_c[1] = mem_rdata_i[7:0];
            app_c[2] = 8'h00;
            app_c[3] = 8'h00;
            app_n_c  = 3'd2;
        end else begin
            app_c[0] = mem_rdata_i[31:24];
            app_c[1] = mem_rdata_i[23:16];
            app_c[2] = mem_rdata_i[15:8];
            app_c[3] = mem_rdata_i[7:0];
            app_n_c  = 3'd4;
        end
    end

    // Queue, pc and fetch-address update; redirect overrides consume and ack.
    always_comb begin
        q_d          = q_q;
        count_d      = count_q;
        pc_d         = pc_q;
        fa_d         = fa_q;
        drop_first_d = drop_first_q;
        discard_d    = discard_q;
        err_d        = err_q;
        shift_c      = 3'd0;
        base_c       = count_q;
        ack_take_c   = 1'b0;

        if (redir_i) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_d[i] = 8'h00;
            end
            count_d      = '0;
            pc_d         = {redir_pc_i[31:1], 1'b0};
            fa_d         = {redir_pc_i[31:2], 2'b00};
            drop_first_d = redir_pc_i[1];
            // An in-flight read keeps going but its data belongs to the old stream.
            discard_d    = req_q & ~mem_ack_i;
            if (redir_pc_i[0]) begin
                err_d = 1'b1;
            end
        end else begin
            if (consume_i) begin
                if (valid_c && len_ok_c) begin
                    shift_c = length_i;
                end else begin
                    err_d = 1'b1;
                end
            end

            if (req_q && mem_ack_i) begin
                discard_d = 1'b0;
            end
            ack_take_c = req_q & mem_ack_i & ~discard_q;

            // Shift head out; vacated slots read back as zero.
            for (int i = 0; i < QDEPTH; i++) begin
                q_d[i] = 8'h00;
                if (i + int'(shift_c) < int'(count_q)) begin
                    q_d[i] = q_q[IW'(i + int'(shift_c))];
                end
            end
            base_c  = count_q - CW'(shift_c);
            count_d = base_c;
            pc_d    = pc_q + 32'(shift_c);

            // Append lands right after the surviving bytes; space was reserved at request time.
            if (ack_take_c) begin
                for (int k = 0; k < 4; k++) begin
                    if (k < int'(app_n_c)) begin
                        q_d[IW'(int'(base_c) + k)] = app_c[k];
                    end
                end
                count_d      = base_c + CW'(app_n_c);
                fa_d         = fa_q + 32'd4;
                drop_first_d = 1'b0;
            end
        end
    end

    // Request control: hold until ack, otherwise issue whenever a full word fits.
    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        if (!(req_q && !mem_ack_i)) begin
            req_d = (count_d <= REQ_LIMIT);
            if (req_d) begin
                addr_d = fa_d;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_q[i] <= 8'h00;
            end
            count_q      <= '0;
            pc_q         <= RESET_PC;
            fa_q         <= RESET_FA;
            drop_first_q <= RESET_PC[1];
            discard_q    <= 1'b0;
            req_q        <= 1'b0;
            addr_q       <= RESET_FA;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_q[i] <= q_d[i];
            end
            count_q      <= count_d;
            pc_q         <= pc_d;
            fa_q         <= fa_d;
            drop_first_q <= drop_first_d;
            discard_q    <= discard_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
        end
    end

    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign valid_o    = valid_c;
    assign insn_o     = {q_q[0], q_q[1]};
    assign data_o     = {q_q[2], q_q[3], q_q[4], q_q[5]};
    assign pc_o       = pc_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_moxie_fetch_queue.sv
// tb_moxie_fetch_queue: scoreboard bench for moxie_fetch_queue. The reference model is
// a byte-addressed memory view plus a program counter; every accepted instruction is
// expected to show the bytes at the model pc.
module tb_moxie_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        redir_i = 1'b0;
    logic [31:0] redir_pc_i = 32'h0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        valid_o;
    logic [15:0] insn_o;
    logic [31:0] data_o;
    logic [31:0] pc_o;
    logic        consume_i = 1'b0;
    logic [2:0]  length_i = 3'd0;
    logic        err_o;

    moxie_fetch_queue #(.QDEPTH(12), .RESET_PC(RESET_PC)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .redir_i     (redir_i),
        .redir_pc_i  (redir_pc_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .valid_o     (valid_o),
        .insn_o      (insn_o),
        .data_o      (data_o),
        .pc_o        (pc_o),
        .consume_i   (consume_i),
        .length_i    (length_i),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] insn;
        logic [31:0] data;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        exp_q[$];
    logic [31:0] model_pc = RESET_PC;
    int          delay_cfg = 0;
    bit          stray_ack = 1'b0;
    bit          busy = 1'b0;
    int          wcnt = 0;
    logic [31:0] req_addr = 32'h0;

    // Instruction memory contents: fixed words for directed cases, hash elsewhere.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'h0102_0304;
            32'h0000_1004: return 32'h0506_0708;
            32'h0000_2000: return 32'hAABB_CCDD;
            32'h0000_2004: return 32'h1122_3344;
            default:       return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
        endcase
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = word_at({a[31:2], 2'b00});
        case (a[1:0])
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Memory responder: configurable wait states, checks request stability.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            if (!rst_ni) begin
                busy = 1'b0;
                if (stray_ack) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = 32'hDEAD_BEEF;
                    stray_ack   = 1'b0;
                end
            end else if (mem_req_o) begin
                if (!busy) begin
                    busy     = 1'b1;
                    req_addr = mem_addr_o;
                    wcnt     = (delay_cfg < 0) ? int'($urandom_range(3, 0)) : delay_cfg;
                    chk("addr_align", 32'(mem_addr_o[1:0]), 32'd0);
                end else begin
                    chk("addr_stable", mem_addr_o, req_addr);
                end
                if (wcnt == 0) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = word_at(mem_addr_o);
                    busy        = 1'b0;
                end else begin
                    wcnt--;
                end
            end else begin
                if (busy) chk("req_held", 32'(mem_req_o), 32'd1);
                busy = 1'b0;
            end
        end
    end

    // Monitor: every accepted legal consume pops one expected window.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && consume_i && valid_o &&
                (length_i == 3'd2 || length_i == 3'd4 || length_i == 3'd6)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: consume with no expected entry (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", pc_o, e.pc);
                    chk("sb_insn", 32'(insn_o), 32'(e.insn));
                    chk("sb_data", data_o, e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
        consume_i = 1'b0;
        redir_i   = 1'b0;
        length_i  = 3'd0;
    endtask

    task automatic push_consume(input logic [2:0] len);
        exp_t e;
        e.pc   = model_pc;
        e.insn = {byte_at(model_pc), byte_at(model_pc + 32'd1)};
        e.data = {byte_at(model_pc + 32'd2), byte_at(model_pc + 32'd3),
                  byte_at(model_pc + 32'd4), byte_at(model_pc + 32'd5)};
        exp_q.push_back(e);
        model_pc  = model_pc + 32'(len);
        consume_i = 1'b1;
        length_i  = len;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!valid_o && n < max) begin
            tick();
            n++;
        end
        if (!valid_o) timeout("wait_valid");
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (mem_req_o && n < max) begin
            tick();
            n++;
        end
        if (mem_req_o) timeout("wait_idle");
    endtask

    task automatic consume_one(input logic [2:0] len);
        wait_valid(60);
        if (valid_o) push_consume(len);
        tick();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redir_i    = 1'b1;
        redir_pc_i = pc;
        model_pc   = {pc[31:1], 1'b0};
        tick();
    endtask

    task automatic do_reset();
        rst_ni   = 1'b0;
        model_pc = RESET_PC;
        exp_q.delete();
        tick();
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_insn", 32'(insn_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_pc", pc_o, RESET_PC);
        chk("rst_err", 32'(err_o), 32'd0);
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic run_random(input int cycles, input int cons_pct, input int redir_permil);
        logic [31:0] r;
        for (int c = 0; c < cycles; c++) begin
            if (int'($urandom_range(999, 0)) < redir_permil) begin
                r = $urandom;
                if ($urandom_range(3, 0) == 0) r = 32'hFFFF_FFF0 | (r & 32'h0000_000F);
                r[0] = 1'b0;
                redir_i    = 1'b1;
                redir_pc_i = r;
                model_pc   = r;
            end else if (valid_o && int'($urandom_range(99, 0)) < cons_pct) begin
                case ($urandom_range(2, 0))
                    0:       push_consume(3'd2);
                    1:       push_consume(3'd4);
                    default: push_consume(3'd6);
                endcase
            end
            tick();
        end
    endtask

    initial begin
        logic [31:0] first_addr;
        logic [31:0] pc_before;
        bit          seen;
        int          lat;
        int          n;

        // Reset and first window
        delay_cfg = 0;
        tick();
        do_reset();
        wait_valid(20);
        chk("t1_pc", pc_o, 32'h0000_1000);
        chk("t1_insn", 32'(insn_o), 32'h0000_0102);
        chk("t1_data", data_o, 32'h0304_0506);

        // Consume 2 then 6
        push_consume(3'd2);
        tick();
        wait_valid(20);
        chk("t2_pc2", pc_o, 32'h0000_1002);
        chk("t2_insn2", 32'(insn_o), 32'h0000_0304);
        chk("t2_data2", data_o, 32'h0506_0708);
        push_consume(3'd6);
        tick();
        wait_valid(20);
        chk("t2_pc8", pc_o, 32'h0000_1008);
        chk("t2_insn8", 32'(insn_o), 32'({byte_at(32'h1008), byte_at(32'h1009)}));

        // Redirect to half-word-aligned target
        wait_idle(60);
        do_redirect(32'h0000_2002);
        lat  = 1;
        seen = 1'b0;
        first_addr = 32'h0;
        while (1) begin
            if (mem_req_o && !seen) begin
                seen = 1'b1;
                first_addr = mem_addr_o;
            end
            if (valid_o || lat > 30) break;
            tick();
            lat++;
        end
        chk("t3_first_req", first_addr, 32'h0000_2000);
        chk("t3_latency_ge3", 32'(lat >= 3), 32'd1);
        chk("t3_valid", 32'(valid_o), 32'd1);
        chk("t3_insn", 32'(insn_o), 32'h0000_CCDD);
        chk("t3_data", data_o, 32'h1122_3344);
        chk("t3_pc", pc_o, 32'h0000_2002);
        consume_one(3'd4);

        // Redirect while the read of 0x1010 is outstanding
        wait_idle(60);
        do_redirect(32'h0000_1000);
        wait_idle(60);
        wait_valid(20);
        push_consume(3'd6);
        tick();
        wait_idle(60);
        delay_cfg = 5;
        wait_valid(20);
        push_consume(3'd2);
        tick();
        n = 0;
        while (!(mem_req_o && mem_addr_o == 32'h0000_1010) && n < 20) begin
            tick();
            n++;
        end
        chk("t4_stale_req", mem_addr_o, 32'h0000_1010);
        tick();
        do_redirect(32'h0000_3000);
        chk("t4_flush_valid", 32'(valid_o), 32'd0);
        n = 0;
        first_addr = 32'h0;
        while (n < 30) begin
            if (mem_req_o && mem_addr_o != 32'h0000_1010) begin
                first_addr = mem_addr_o;
                break;
            end
            tick();
            n++;
        end
        chk("t4_next_req", first_addr, 32'h0000_3000);
        delay_cfg = 0;
        consume_one(3'd2);
        consume_one(3'd6);
        consume_one(3'd4);

        // Stalled consumer: queue fills, fetch stops, then resumes
        delay_cfg = -1;
        for (int c = 0; c < 60; c++) tick();
        chk("t5_req_stalled", 32'(mem_req_o), 32'd0);
        chk("t5_valid_stalled", 32'(valid_o), 32'd1);
        run_random(400, 60, 0);

        // Random traffic with redirects
        run_random(2500, 55, 8);
        tick();
        tick();
        chk("rand_no_err", 32'(err_o), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        // Illegal length
        wait_valid(60);
        pc_before  = pc_o;
        consume_i  = 1'b1;
        length_i   = 3'd3;
        tick();
        tick();
        chk("t6_err_len", 32'(err_o), 32'd1);
        chk("t6_pc_len", pc_o, pc_before);

        // Consume with an empty window
        delay_cfg = 0;
        do_reset();
        chk("t6_valid_low", 32'(valid_o), 32'd0);
        consume_i = 1'b1;
        length_i  = 3'd2;
        tick();
        tick();
        chk("t6_err_novalid", 32'(err_o), 32'd1);
        chk("t6_pc_novalid", pc_o, RESET_PC);

        // Odd redirect target: bit 0 ignored, error flagged
        do_reset();
        wait_idle(60);
        do_redirect(32'h0000_2003);
        chk("odd_err", 32'(err_o), 32'd1);
        chk("odd_pc", pc_o, 32'h0000_2002);
        consume_one(3'd2);
        consume_one(3'd6);

        // Reset in the middle of a request; an ack during reset is ignored
        delay_cfg = 5;
        do_reset();
        n = 0;
        while (!mem_req_o && n < 20) begin
            tick();
            n++;
        end
        tick();
        rst_ni = 1'b0;
        #1;
        chk("midreq_req_drop", 32'(mem_req_o), 32'd0);
        stray_ack = 1'b1;
        tick();
        tick();
        rst_ni    = 1'b1;
        model_pc  = RESET_PC;
        exp_q.delete();
        delay_cfg = 0;
        consume_one(3'd6);
        consume_one(3'd2);
        run_random(150, 50, 0);
        tick();
        tick();
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
